// File: rtl/ball_packet_i2c_tx_if.sv
// Bus bundle between the ball-state I2C writer and its surroundings:
// packet inputs, open-drain line controls and transfer status.
interface ball_packet_i2c_tx_if;
  logic       ball_send_trigger;
  logic [9:0] ball_y;
  logic [7:0] ball_vy;
  logic [1:0] gravity_counter;
  logic [7:0] ball_speed_reg0;
  logic [7:0] ball_speed_reg1;
  logic [3:0] ball_speed_reg2;
  logic       sda_in;
  logic       scl_in;
  logic       sda_oe;
  logic       scl_oe;
  logic       busy;
  logic       tx_done;
  logic       nack_err;

  modport master (
    input  ball_send_trigger, ball_y, ball_vy, gravity_counter,
    input  ball_speed_reg0, ball_speed_reg1, ball_speed_reg2,
    input  sda_in, scl_in,
    output sda_oe, scl_oe, busy, tx_done, nack_err
  );

  modport slave (
    output ball_send_trigger, ball_y, ball_vy, gravity_counter,
    output ball_speed_reg0, ball_speed_reg1, ball_speed_reg2,
    output sda_in, scl_in,
    input  sda_oe, scl_oe, busy, tx_done, nack_err
  );
endinterface

// File: rtl/ball_packet_i2c_tx.sv
// Ball-state I2C burst writer: START, addr+W, pointer 0x00, 7 packet bytes, STOP.
// Defining BALL_TX_RETRY_EN adds NACK retries (STOP, 64-quarter gap, full resend).
module ball_packet_i2c_tx #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h2A,
  parameter int unsigned QTR_DIV    = 62,
  parameter int unsigned MAX_RETRY  = 3
) (
  input logic                  clk_25MHZ,
  input logic                  reset_n,
  ball_packet_i2c_tx_if.master bus
);
  localparam int unsigned QW = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE, START, SEND_BYTE, GET_ACK, STOP, FINISH
`ifdef BALL_TX_RETRY_EN
    , RETRY_WAIT
`endif
  } state_t;

  state_t        r_state, w_state_n;
  logic          r_trig, r_trig_d, w_rise;
  logic [7:0]    r_pkt [7];
  logic [7:0]    r_shift, w_next_byte;
  logic [2:0]    r_bit;
  logic [3:0]    r_byte;
  logic [1:0]    r_qtr;
  logic [QW-1:0] r_qcnt;
  logic          r_nack;
  logic          w_stretch, w_qend, w_last_q;
  logic          w_sda_oe, w_scl_oe;
`ifdef BALL_TX_RETRY_EN
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] r_retry;
  logic [5:0]    r_wait;
  logic          w_wait_end;
  assign w_wait_end = (r_state == RETRY_WAIT) && w_qend && (r_wait == 6'd63);
`endif

  assign w_rise    = r_trig & ~r_trig_d;
  // A slave holding SCL low while we release it freezes the quarter timer.
  assign w_stretch = ((r_state == SEND_BYTE) || (r_state == GET_ACK)) && r_qtr[1]
                     && !w_scl_oe && !bus.scl_in;
  assign w_qend    = (r_qcnt == QW'(QTR_DIV - 1)) && !w_stretch;
  assign w_last_q  = w_qend && (r_qtr == 2'd3);

  assign bus.sda_oe = w_sda_oe;
  assign bus.scl_oe = w_scl_oe;
  assign bus.busy   = (r_state != IDLE) && (r_state != FINISH);

  always_comb begin
    w_next_byte = 8'h00;
    if ((r_byte != 4'd0) && (r_byte < 4'd8))
      w_next_byte = r_pkt[3'(r_byte - 4'd1)];
  end

  always_ff @(posedge clk_25MHZ or negedge reset_n) begin
    if (!reset_n) begin
      r_trig   <= 1'b0;
      r_trig_d <= 1'b0;
      r_state  <= IDLE;
    end else begin
      r_trig   <= bus.ball_send_trigger;
      r_trig_d <= r_trig;
      r_state  <= w_state_n;
    end
  end

  always_ff @(posedge clk_25MHZ or negedge reset_n) begin
    if (!reset_n) begin
      r_qcnt <= '0;
      r_qtr  <= '0;
    end else if ((r_state == IDLE) || (r_state == FINISH)) begin
      r_qcnt <= '0;
      r_qtr  <= '0;
    end else if (w_qend) begin
      r_qcnt <= '0;
      r_qtr  <= r_qtr + 2'd1;
    end else if (!w_stretch) begin
      r_qcnt <= r_qcnt + 1'b1;
    end
  end

  always_ff @(posedge clk_25MHZ or negedge reset_n) begin
    if (!reset_n) begin
      r_pkt   <= '{default: '0};
      r_shift <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_nack  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_rise) begin
          r_pkt[0] <= {bus.ball_y[9:8], 6'b0};
          r_pkt[1] <= bus.ball_y[7:0];
          r_pkt[2] <= bus.ball_vy;
          r_pkt[3] <= {6'b0, bus.gravity_counter};
          r_pkt[4] <= bus.ball_speed_reg0;
          r_pkt[5] <= bus.ball_speed_reg1;
          r_pkt[6] <= {4'b0, bus.ball_speed_reg2};
          r_shift  <= {SLAVE_ADDR, 1'b0};
          r_bit    <= '0;
          r_byte   <= '0;
          r_nack   <= 1'b0;
        end
        SEND_BYTE: if (w_last_q) begin
          r_bit   <= r_bit + 3'd1;
          r_shift <= {r_shift[6:0], 1'b0};
        end
        GET_ACK: if (w_last_q) begin
          if (bus.sda_in) begin
            r_nack <= 1'b1;
          end else if (r_byte != 4'd8) begin
            r_byte  <= r_byte + 4'd1;
            r_shift <= w_next_byte;
          end
        end
`ifdef BALL_TX_RETRY_EN
        RETRY_WAIT: if (w_wait_end) begin
          r_shift <= {SLAVE_ADDR, 1'b0};
          r_byte  <= '0;
          r_nack  <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef BALL_TX_RETRY_EN
  always_ff @(posedge clk_25MHZ or negedge reset_n) begin
    if (!reset_n) begin
      r_retry <= '0;
      r_wait  <= '0;
    end else begin
      if ((r_state == IDLE) && w_rise) r_retry <= '0;
      else if (w_wait_end)             r_retry <= r_retry + 1'b1;
      if (r_state != RETRY_WAIT) r_wait <= '0;
      else if (w_qend)           r_wait <= r_wait + 6'd1;
    end
  end
`endif

  always_comb begin
    w_state_n    = r_state;
    w_sda_oe     = 1'b0;
    w_scl_oe     = 1'b0;
    bus.tx_done  = 1'b0;
    bus.nack_err = 1'b0;
    case (r_state)
      IDLE: if (w_rise) w_state_n = START;
      START: begin
        w_sda_oe = r_qtr[1];
        if (w_last_q) w_state_n = SEND_BYTE;
      end
      SEND_BYTE: begin
        w_scl_oe = ~r_qtr[1];
        w_sda_oe = ~r_shift[7];
        if (w_last_q && (r_bit == 3'd7)) w_state_n = GET_ACK;
      end
      GET_ACK: begin
        w_scl_oe = ~r_qtr[1];
        if (w_last_q)
          w_state_n = (bus.sda_in || (r_byte == 4'd8)) ? STOP : SEND_BYTE;
      end
      STOP: begin
        w_sda_oe = (r_qtr != 2'd3);
        w_scl_oe = (r_qtr == 2'd0);
        if (w_last_q) begin
`ifdef BALL_TX_RETRY_EN
          w_state_n = (r_nack && (r_retry < RW'(MAX_RETRY))) ? RETRY_WAIT : FINISH;
`else
          w_state_n = FINISH;
`endif
        end
      end
      FINISH: begin
        bus.tx_done  = ~r_nack;
        bus.nack_err = r_nack;
        w_state_n    = IDLE;
      end
`ifdef BALL_TX_RETRY_EN
      RETRY_WAIT: if (w_wait_end) w_state_n = START;
`endif
      default: w_state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ball_packet_i2c_tx.sv
// Directed bench: negedge-sampled I2C slave model decodes wire bytes and checks them
// against a queue of expected bytes pushed when each request is driven.
module tb_ball_packet_i2c_tx;
  localparam int unsigned Q = 8;
  localparam int BASE_LAT = 2 + 9 * 9 * 4 * Q + 8 * Q;
`ifdef BALL_TX_RETRY_EN
  localparam int NACK_LAT = 2 + 4 * 44 * Q + 3 * 64 * Q;
  localparam int N_ATT    = 4;
`else
  localparam int NACK_LAT = 2 + 44 * Q;
  localparam int N_ATT    = 1;
`endif

  logic clk_25MHZ = 1'b0;
  logic reset_n   = 1'b0;
  always #20 clk_25MHZ = ~clk_25MHZ;

  ball_packet_i2c_tx_if bif ();
  ball_packet_i2c_tx #(.SLAVE_ADDR(7'h2A), .QTR_DIV(Q), .MAX_RETRY(3)) dut (
    .clk_25MHZ(clk_25MHZ), .reset_n(reset_n), .bus(bif)
  );

  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  logic slv_drv = 0, hold = 0, hold_pend = 0, stretch_arm = 0, nack_addr = 0;
  logic seen_rise = 0, prev_scl = 1, prev_sda = 1, cs, cd;
  logic [7:0] sh = '0;
  int hold_cnt = 0, bitcnt = 0, nbytes = 0, starts = 0, n_done = 0, n_nack = 0;

  assign bif.scl_in = ~bif.scl_oe & ~hold;
  assign bif.sda_in = ~bif.sda_oe & ~slv_drv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic got_byte(input logic [7:0] b);
    chk("byte_was_expected", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) chk("wire_byte", b, exp_q.pop_front());
  endtask

  always @(negedge clk_25MHZ) begin
    if (bif.tx_done)  n_done++;
    if (bif.nack_err) n_nack++;
  end

  // Slave model working on negedge samples of the resolved lines.
  always @(negedge clk_25MHZ) begin
    if (!reset_n) begin
      slv_drv = 0; hold = 0; hold_pend = 0; hold_cnt = 0;
      bitcnt = 0; seen_rise = 0; prev_scl = 1; prev_sda = 1;
    end else begin
      if (hold_pend && !bif.scl_oe) begin
        hold = 1; hold_cnt = 500; hold_pend = 0;
      end else if (hold) begin
        hold_cnt--;
        if (hold_cnt == 0) hold = 0;
      end
      cs = !bif.scl_oe && !hold;
      cd = !bif.sda_oe && !slv_drv;
      if (prev_scl && cs && prev_sda && !cd) begin
        starts++; bitcnt = 0; nbytes = 0; seen_rise = 0; slv_drv = 0;
      end else if (prev_scl && cs && !prev_sda && cd) begin
        bitcnt = 0; seen_rise = 0; slv_drv = 0;
      end else if (!prev_scl && cs) begin
        seen_rise = 1;
        if (bitcnt < 8) sh = {sh[6:0], cd};
      end else if (prev_scl && !cs && seen_rise) begin
        seen_rise = 0;
        if (bitcnt < 7) bitcnt++;
        else if (bitcnt == 7) begin
          bitcnt = 8;
          got_byte(sh);
          slv_drv = !(nack_addr && nbytes == 0);
          nbytes++;
        end else begin
          bitcnt = 0; slv_drv = 0;
        end
        if (stretch_arm && nbytes == 4 && bitcnt == 3) begin
          hold_pend = 1; stretch_arm = 0;
        end
      end
      prev_scl = cs; prev_sda = cd;
    end
  end

  task automatic drive_pkt(input logic [9:0] y, input logic [7:0] vy,
                           input logic [1:0] g, input logic [19:0] sp);
    bif.ball_y = y; bif.ball_vy = vy; bif.gravity_counter = g;
    bif.ball_speed_reg0 = sp[7:0]; bif.ball_speed_reg1 = sp[15:8];
    bif.ball_speed_reg2 = sp[19:16];
    exp_q.push_back({7'h2A, 1'b0});
    exp_q.push_back(8'h00);
    exp_q.push_back({y[9:8], 6'b0});
    exp_q.push_back(y[7:0]);
    exp_q.push_back(vy);
    exp_q.push_back({6'b0, g});
    exp_q.push_back(sp[7:0]);
    exp_q.push_back(sp[15:8]);
    exp_q.push_back({4'b0, sp[19:16]});
  endtask

  task automatic fire();
    @(negedge clk_25MHZ);
    bif.ball_send_trigger = 1;
  endtask

  task automatic wait_end(output int lat, output logic busy2);
    lat = 0; busy2 = 0;
    while (lat < 40000 && !(bif.tx_done || bif.nack_err)) begin
      @(negedge clk_25MHZ);
      lat++;
      if (lat == 2) busy2 = bif.busy;
    end
    chk("end_within_budget", lat < 40000, 1);
  endtask

  initial begin
    #8000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, s0, d0, n0;
    logic b2;
    logic [7:0] t1 [9];
    t1 = '{8'h54, 8'h00, 8'h80, 8'hC5, 8'hFD, 8'h02, 8'hB0, 8'h1E, 8'h04};
    bif.ball_send_trigger = 0;
    bif.ball_y = '0; bif.ball_vy = '0; bif.gravity_counter = '0;
    bif.ball_speed_reg0 = '0; bif.ball_speed_reg1 = '0; bif.ball_speed_reg2 = '0;

    repeat (3) @(negedge clk_25MHZ);
    chk("rst_sda_oe", bif.sda_oe, 0);
    chk("rst_scl_oe", bif.scl_oe, 0);
    chk("rst_busy", bif.busy, 0);
    chk("rst_tx_done", bif.tx_done, 0);
    chk("rst_nack_err", bif.nack_err, 0);
    reset_n = 1;
    repeat (3) @(negedge clk_25MHZ);

    // Reference packet with literal wire bytes.
    bif.ball_y = 10'h2C5; bif.ball_vy = 8'hFD; bif.gravity_counter = 2'd2;
    bif.ball_speed_reg0 = 8'hB0; bif.ball_speed_reg1 = 8'h1E; bif.ball_speed_reg2 = 4'h4;
    foreach (t1[i]) exp_q.push_back(t1[i]);
    s0 = starts; d0 = n_done;
    fire();
    wait_end(lat, b2);
    chk("t1_latency", lat, BASE_LAT);
    chk("t1_busy_after_edge", b2, 1);
    chk("t1_tx_done", bif.tx_done, 1);
    chk("t1_busy_in_finish", bif.busy, 0);
    bif.ball_send_trigger = 0;
    @(negedge clk_25MHZ);
    chk("t1_done_one_cycle", bif.tx_done, 0);
    chk("t1_queue_empty", exp_q.size(), 0);
    chk("t1_starts", starts - s0, 1);

    // Address NACK.
    repeat (5) @(negedge clk_25MHZ);
    nack_addr = 1; s0 = starts; d0 = n_done; n0 = n_nack;
    for (int i = 0; i < N_ATT; i++) exp_q.push_back(8'h54);
    bif.ball_y = 10'h155;
    fire();
    wait_end(lat, b2);
    chk("nack_latency", lat, NACK_LAT);
    chk("nack_err_pulse", bif.nack_err, 1);
    chk("nack_no_tx_done", bif.tx_done, 0);
    bif.ball_send_trigger = 0;
    repeat (3) @(negedge clk_25MHZ);
    chk("nack_attempts", starts - s0, N_ATT);
    chk("nack_err_count", n_nack - n0, 1);
    chk("nack_done_count", n_done - d0, 0);
    chk("nack_queue_empty", exp_q.size(), 0);
    nack_addr = 0;

    // Clock stretch during bit 3 of B2.
    repeat (5) @(negedge clk_25MHZ);
    drive_pkt(10'($urandom), 8'($urandom), 2'($urandom), 20'($urandom));
    stretch_arm = 1;
    fire();
    wait_end(lat, b2);
    chk("stretch_latency", lat, BASE_LAT + 500);
    chk("stretch_tx_done", bif.tx_done, 1);
    bif.ball_send_trigger = 0;
    @(negedge clk_25MHZ);
    chk("stretch_applied", stretch_arm, 0);
    chk("stretch_queue_empty", exp_q.size(), 0);

    // Second rise mid-transfer is dropped.
    repeat (5) @(negedge clk_25MHZ);
    s0 = starts; d0 = n_done;
    drive_pkt(10'h3FF, 8'h80, 2'd3, 20'hFFFFF);
    fire();
    repeat (300) @(negedge clk_25MHZ);
    bif.ball_send_trigger = 0;
    repeat (50) @(negedge clk_25MHZ);
    bif.ball_send_trigger = 1;
    wait_end(lat, b2);
    repeat (200) @(negedge clk_25MHZ);
    chk("mid_busy_idle", bif.busy, 0);
    chk("mid_starts", starts - s0, 1);
    chk("mid_done_count", n_done - d0, 1);
    chk("mid_queue_empty", exp_q.size(), 0);
    bif.ball_send_trigger = 0;

    // Reset during B4, then a clean resend.
    repeat (5) @(negedge clk_25MHZ);
    drive_pkt(10'($urandom), 8'($urandom), 2'($urandom), 20'($urandom));
    fire();
    lat = 0;
    while (nbytes < 6 && lat < 40000) begin
      @(negedge clk_25MHZ);
      lat++;
    end
    chk("rst_reached_b4", nbytes >= 6, 1);
    repeat (8 * Q) @(negedge clk_25MHZ);
    #3 reset_n = 0;
    bif.ball_send_trigger = 0;
    #1;
    chk("midrst_sda_oe", bif.sda_oe, 0);
    chk("midrst_scl_oe", bif.scl_oe, 0);
    chk("midrst_busy", bif.busy, 0);
    exp_q.delete();
    repeat (3) @(negedge clk_25MHZ);
    reset_n = 1;
    repeat (3) @(negedge clk_25MHZ);
    s0 = starts;
    drive_pkt(10'h0AA, 8'h7F, 2'd1, 20'h12345);
    fire();
    wait_end(lat, b2);
    chk("postrst_latency", lat, BASE_LAT);
    chk("postrst_starts", starts - s0, 1);
    chk("postrst_queue_empty", exp_q.size(), 0);
    bif.ball_send_trigger = 0;

    // Trigger held high for 1000 cycles.
    repeat (5) @(negedge clk_25MHZ);
    s0 = starts; d0 = n_done;
    drive_pkt(10'h201, 8'h01, 2'd0, 20'h80001);
    fire();
    repeat (1000) @(negedge clk_25MHZ);
    bif.ball_send_trigger = 0;
    wait_end(lat, b2);
    chk("held_latency", lat + 1000, BASE_LAT);
    repeat (100) @(negedge clk_25MHZ);
    chk("held_busy_idle", bif.busy, 0);
    chk("held_single_start", starts - s0, 1);
    chk("held_done_count", n_done - d0, 1);
    drive_pkt(10'h1C3, 8'hC3, 2'd2, 20'h0F0F0);
    fire();
    wait_end(lat, b2);
    chk("held_new_latency", lat, BASE_LAT);
    bif.ball_send_trigger = 0;
    repeat (3) @(negedge clk_25MHZ);
    chk("held_new_starts", starts - s0, 2);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
